// File: rtl/darksocv_memarb_if.sv
// Shared bus bundle for the two-requester memory arbiter: both requester
// ports, the memory-side handshake and the grant status.
interface darksocv_memarb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // requester 0
  logic          req0;
  logic          wr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] dato0;
  logic [DW/8-1:0] be0;
  logic          ack0;
  logic          err0;
  logic [DW-1:0] dati0;
  // requester 1
  logic          req1;
  logic          wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dato1;
  logic [DW/8-1:0] be1;
  logic          ack1;
  logic          err1;
  logic [DW-1:0] dati1;
  // memory side
  logic          mreq;
  logic          mwr;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdato;
  logic [DW/8-1:0] mbe;
  logic [DW-1:0] mdati;
  logic          mrdy;
  // status
  logic          gnt;

  // Arbiter view.
  modport slave (
    input  req0, wr0, addr0, dato0, be0,
    input  req1, wr1, addr1, dato1, be1,
    input  mdati, mrdy,
    output ack0, err0, dati0,
    output ack1, err1, dati1,
    output mreq, mwr, maddr, mdato, mbe,
    output gnt
  );

  // Requester/memory view.
  modport master (
    output req0, wr0, addr0, dato0, be0,
    output req1, wr1, addr1, dato1, be1,
    output mdati, mrdy,
    input  ack0, err0, dati0,
    input  ack1, err1, dati1,
    input  mreq, mwr, maddr, mdato, mbe,
    input  gnt
  );
endinterface

// File: rtl/darksocv_memarb.sv
// Two-requester round-robin arbiter for the shared memory bus. Each
// transaction runs IDLE -> BUSY -> RESP; a watchdog aborts a BUSY phase the
// memory never completes and reports it on the requester's err line.
module darksocv_memarb #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned TOUT = 64
) (
  input  logic              clk,
  input  logic              res,
  darksocv_memarb_if.slave  bus
);

  localparam int unsigned CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic            gnt_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic            ack0_q, ack1_q;
  logic            err0_q, err1_q;
  logic [DW-1:0]   dati0_q, dati1_q;

  logic            pick;
  logic            timeout;
  logic            busy;
  logic            mwr_c;
  logic [AW-1:0]   maddr_c;
  logic [DW-1:0]   mdato_c;
  logic [DW/8-1:0] mbe_c;

  // Winner of an IDLE-cycle arbitration: a tie goes to the one not granted last.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      pick = ~last_q;
    end else begin
      pick = bus.req1;
    end
  end

  // Watchdog fires on the last allowed wait cycle unless memory completes in it.
  always_comb begin
    timeout = (TOUT != 0) && !bus.mrdy && (cnt_q == CW'(TOUT - 1));
  end

  // Arbitration FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      dati0_q <= '0;
      dati1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            gnt_q   <= pick;
            last_q  <= pick;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (bus.mrdy) begin
            if (gnt_q) begin
              dati1_q <= bus.mdati;
              ack1_q  <= 1'b1;
            end else begin
              dati0_q <= bus.mdati;
              ack0_q  <= 1'b1;
            end
            state_q <= StResp;
          end else if (timeout) begin
            if (gnt_q) begin
              dati1_q <= '0;
              ack1_q  <= 1'b1;
              err1_q  <= 1'b1;
            end else begin
              dati0_q <= '0;
              ack0_q  <= 1'b1;
              err0_q  <= 1'b1;
            end
            state_q <= StResp;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory-side fields follow the granted requester only while BUSY.
  always_comb begin
    busy    = (state_q == StBusy);
    mwr_c   = 1'b0;
    maddr_c = '0;
    mdato_c = '0;
    mbe_c   = '0;
    if (busy) begin
      if (gnt_q) begin
        mwr_c   = bus.wr1;
        maddr_c = bus.addr1;
        mdato_c = bus.dato1;
        mbe_c   = bus.be1;
      end else begin
        mwr_c   = bus.wr0;
        maddr_c = bus.addr0;
        mdato_c = bus.dato0;
        mbe_c   = bus.be0;
      end
    end
  end

  assign bus.mreq  = busy;
  assign bus.mwr   = mwr_c;
  assign bus.maddr = maddr_c;
  assign bus.mdato = mdato_c;
  assign bus.mbe   = mbe_c;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.err0  = err0_q;
  assign bus.err1  = err1_q;
  assign bus.dati0 = dati0_q;
  assign bus.dati1 = dati1_q;
  assign bus.gnt   = gnt_q;

endmodule

// File: tb/tb_darksocv_memarb.sv
// Bench for darksocv_memarb: directed scenarios with literal expectations,
// then random requesters/memory checked every cycle against a
// transaction-level model of the arbiter.
module tb_darksocv_memarb;

  localparam int unsigned TOUT = 4;

  logic clk = 1'b0;
  logic res;

  always #5 clk = ~clk;

  darksocv_memarb_if #(.AW(32), .DW(32)) bus ();

  darksocv_memarb #(.AW(32), .DW(32), .TOUT(TOUT)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Requester and memory stimulus.
  logic        req_v  [2];
  logic        wr_v   [2];
  logic [31:0] addr_v [2];
  logic [31:0] dato_v [2];
  logic [3:0]  be_v   [2];
  logic        mrdy_v;
  logic [31:0] mdati_v;

  assign bus.req0  = req_v[0];
  assign bus.wr0   = wr_v[0];
  assign bus.addr0 = addr_v[0];
  assign bus.dato0 = dato_v[0];
  assign bus.be0   = be_v[0];
  assign bus.req1  = req_v[1];
  assign bus.wr1   = wr_v[1];
  assign bus.addr1 = addr_v[1];
  assign bus.dato1 = dato_v[1];
  assign bus.be1   = be_v[1];
  assign bus.mrdy  = mrdy_v;
  assign bus.mdati = mdati_v;

  // Model: owner is the requester whose memory phase is in progress (-1 none),
  // resp_owner the requester being acknowledged this cycle (-1 none).
  int          owner;
  int          resp_owner;
  bit          resp_err;
  int          waited;
  int          last_g;
  int          gnt_m;
  int          mem_lat;
  logic [31:0] dati_m [2];
  bit          acked_prev [2];

  bit auto_req;
  bit auto_mem;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    owner      = -1;
    resp_owner = -1;
    resp_err   = 1'b0;
    waited     = 0;
    last_g     = 1;
    gnt_m      = 0;
    dati_m[0]  = '0;
    dati_m[1]  = '0;
  endtask

  task automatic check_outputs();
    int oi;
    bit b;
    oi = (owner < 0) ? 0 : owner;
    b  = (owner >= 0);
    chk("mreq",  bus.mreq,  b);
    chk("mwr",   bus.mwr,   b ? wr_v[oi]   : 1'b0);
    chk("maddr", bus.maddr, b ? addr_v[oi] : 32'h0);
    chk("mdato", bus.mdato, b ? dato_v[oi] : 32'h0);
    chk("mbe",   bus.mbe,   b ? be_v[oi]   : 4'h0);
    chk("ack0",  bus.ack0,  resp_owner == 0);
    chk("ack1",  bus.ack1,  resp_owner == 1);
    chk("err0",  bus.err0,  (resp_owner == 0) && resp_err);
    chk("err1",  bus.err1,  (resp_owner == 1) && resp_err);
    chk("dati0", bus.dati0, dati_m[0]);
    chk("dati1", bus.dati1, dati_m[1]);
    chk("gnt",   bus.gnt,   gnt_m[0]);
    chk("ack_excl", bus.ack0 & bus.ack1, 1'b0);
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic update_model();
    acked_prev[0] = (resp_owner == 0);
    acked_prev[1] = (resp_owner == 1);
    if (res) begin
      model_reset();
    end else if (owner >= 0) begin
      if (mrdy_v) begin
        dati_m[owner] = mdati_v;
        resp_owner    = owner;
        resp_err      = 1'b0;
        owner         = -1;
      end else if (TOUT != 0 && waited == int'(TOUT) - 1) begin
        dati_m[owner] = '0;
        resp_owner    = owner;
        resp_err      = 1'b1;
        owner         = -1;
      end else begin
        waited++;
      end
    end else if (resp_owner >= 0) begin
      resp_owner = -1;
    end else if (req_v[0] || req_v[1]) begin
      if (req_v[0] && req_v[1]) owner = 1 - last_g;
      else owner = req_v[1] ? 1 : 0;
      last_g = owner;
      gnt_m  = owner;
      waited = 0;
      if (auto_mem) mem_lat = $urandom_range(0, 5);
    end
  endtask

  task automatic new_txn(input int n);
    req_v[n]  = 1'b1;
    wr_v[n]   = $urandom_range(0, 1);
    addr_v[n] = $urandom;
    dato_v[n] = $urandom;
    be_v[n]   = 4'($urandom);
  endtask

  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (req_v[n] && acked_prev[n]) begin
        if ($urandom_range(0, 1) == 1) new_txn(n);
        else req_v[n] = 1'b0;
      end else if (!req_v[n] && $urandom_range(0, 2) == 0) begin
        new_txn(n);
      end
    end
    res = ($urandom_range(0, 149) == 0);
  endtask

  task automatic drive_memory();
    if (owner >= 0) mrdy_v = (waited >= mem_lat);
    else mrdy_v = $urandom_range(0, 1);
    mdati_v = $urandom;
  endtask

  // One clock: check at the falling edge, then drive inputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
    if (auto_req) drive_random();
    if (auto_mem) drive_memory();
  endtask

  task automatic reset_mid(input int n);
    req_v[n]  = 1'b1;
    wr_v[n]   = 1'b0;
    addr_v[n] = 32'h600;
    tick();
    chk("t6_busy", bus.mreq, 1'b1);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("t6_mreq", bus.mreq, 1'b0);
    chk("t6_ack0", bus.ack0, 1'b0);
    chk("t6_ack1", bus.ack1, 1'b0);
    chk("t6_gnt",  bus.gnt,  1'b0);
    req_v[n] = 1'b0;
  endtask

  int ord [8];
  int cyc [8];
  int ng;

  initial begin
    auto_req = 1'b0;
    auto_mem = 1'b0;
    mem_lat  = 0;
    res      = 1'b1;
    mrdy_v   = 1'b0;
    mdati_v  = '0;
    for (int n = 0; n < 2; n++) begin
      req_v[n]      = 1'b0;
      wr_v[n]       = 1'b0;
      addr_v[n]     = '0;
      dato_v[n]     = '0;
      be_v[n]       = '0;
      acked_prev[n] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_mreq",  bus.mreq,  1'b0);
    chk("rst_ack0",  bus.ack0,  1'b0);
    chk("rst_ack1",  bus.ack1,  1'b0);
    chk("rst_gnt",   bus.gnt,   1'b0);
    chk("rst_dati0", bus.dati0, 32'h0);
    tick();
    res = 1'b0;

    // Single read on requester 0.
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h100; dato_v[0] = $urandom; be_v[0] = 4'hf;
    tick();
    chk("t1_mreq",  bus.mreq,  1'b1);
    chk("t1_maddr", bus.maddr, 32'h100);
    chk("t1_mwr",   bus.mwr,   1'b0);
    mrdy_v = 1'b1; mdati_v = 32'hCAFEBABE;
    tick();
    chk("t1_ack0",  bus.ack0,  1'b1);
    chk("t1_dati0", bus.dati0, 32'hCAFEBABE);
    chk("t1_ack1",  bus.ack1,  1'b0);
    req_v[0] = 1'b0; mrdy_v = 1'b0;
    tick();

    // Write on requester 1 with memory three cycles late.
    req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 32'h2004; dato_v[1] = 32'h12345678;
    be_v[1] = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_mreq",  bus.mreq,  1'b1);
      chk("t2_maddr", bus.maddr, 32'h2004);
      chk("t2_mdato", bus.mdato, 32'h12345678);
      chk("t2_mbe",   bus.mbe,   4'b0011);
      chk("t2_mwr",   bus.mwr,   1'b1);
      mrdy_v = (i == 3); mdati_v = $urandom;
      tick();
    end
    chk("t2_ack1", bus.ack1, 1'b1);
    chk("t2_err1", bus.err1, 1'b0);
    chk("t2_mreq", bus.mreq, 1'b0);
    req_v[1] = 1'b0; mrdy_v = 1'b0;
    tick();
    chk("t2_ack1_pulse", bus.ack1, 1'b0);

    // Both requesting continuously with immediate memory.
    new_txn(0); new_txn(1); mrdy_v = 1'b1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 8; i++) begin
      mdati_v = $urandom;
      tick();
      if (bus.ack0 || bus.ack1) begin
        ord[ng] = bus.ack1 ? 1 : 0;
        cyc[ng] = i;
        ng++;
      end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0; mrdy_v = 1'b0;
    tick();
    tick();
    chk("t3_count", ng, 8);
    for (int k = 0; k < ng; k++) begin
      chk("t3_order", ord[k], k % 2);
      if (k > 0) chk("t3_spacing", cyc[k] - cyc[k-1], 3);
    end

    // Watchdog abort, then a normal transaction.
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_mreq", bus.mreq, 1'b1);
      tick();
    end
    chk("t4_ack0",  bus.ack0,  1'b1);
    chk("t4_err0",  bus.err0,  1'b1);
    chk("t4_dati0", bus.dati0, 32'h0);
    chk("t4_mreq_low", bus.mreq, 1'b0);
    req_v[0] = 1'b0;
    tick();
    req_v[0] = 1'b1; addr_v[0] = 32'h304;
    tick();
    chk("t4b_mreq", bus.mreq, 1'b1);
    mrdy_v = 1'b1; mdati_v = 32'h5A5A1234;
    tick();
    chk("t4b_ack0",  bus.ack0,  1'b1);
    chk("t4b_err0",  bus.err0,  1'b0);
    chk("t4b_dati0", bus.dati0, 32'h5A5A1234);
    req_v[0] = 1'b0; mrdy_v = 1'b0;
    tick();

    // Memory completes on the last watchdog cycle.
    req_v[0] = 1'b1; addr_v[0] = 32'h400;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_mreq", bus.mreq, 1'b1);
      mrdy_v = (i == 3); mdati_v = 32'h0BADF00D;
      tick();
    end
    chk("t5_ack0",  bus.ack0,  1'b1);
    chk("t5_err0",  bus.err0,  1'b0);
    chk("t5_dati0", bus.dati0, 32'h0BADF00D);
    req_v[0] = 1'b0; mrdy_v = 1'b0;
    tick();

    // Request dropped while granted still completes.
    req_v[0] = 1'b1; addr_v[0] = 32'h500;
    tick();
    req_v[0] = 1'b0;
    tick();
    mrdy_v = 1'b1; mdati_v = 32'h13579BDF;
    tick();
    chk("tdrop_ack0",  bus.ack0,  1'b1);
    chk("tdrop_dati0", bus.dati0, 32'h13579BDF);
    mrdy_v = 1'b0;
    tick();

    // Reset mid-transaction, then a tie goes to requester 0.
    reset_mid(1);
    tick();
    reset_mid(0);
    new_txn(0); new_txn(1);
    tick();
    chk("t6_tie_gnt",  bus.gnt,  1'b0);
    chk("t6_tie_mreq", bus.mreq, 1'b1);
    mrdy_v = 1'b1;
    tick();
    chk("t6_tie_ack0", bus.ack0, 1'b1);
    req_v[0] = 1'b0; req_v[1] = 1'b0; mrdy_v = 1'b0;
    tick();

    // Random traffic against the model.
    auto_req = 1'b1;
    auto_mem = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    auto_req = 1'b0;
    auto_mem = 1'b0;
    res = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/darksocv_memarb.md
Name: darksocv_memarb

Overview:
Two-requester round-robin arbiter sharing the single memory bus between the core data port (requester 0) and the external/test memory port (requester 1, the ifc_mem side). It serializes transactions onto one memory-side request/ready handshake and returns read data and a completion pulse to the granted requester. A watchdog aborts transactions the memory never completes and flags an error instead of hanging the SoC.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables are DW/8 bits)
TOUT, 64, watchdog limit in memory-wait cycles; 0 disables the watchdog

Ports:
CLK  in  1  system clock, all logic on rising edge
RES  in  1  reset, synchronous, active-high
REQ0  in  1  requester 0 transaction request, held until ACK0
WR0  in  1  requester 0 write (1) / read (0)
ADDR0  in  AW  requester 0 address
DATO0  in  DW  requester 0 write data
BE0  in  DW/8  requester 0 byte enables
ACK0  out  1  requester 0 completion pulse, 1 cycle
ERR0  out  1  requester 0 watchdog abort, valid with ACK0
DATI0  out  DW  requester 0 read data, valid with ACK0
REQ1, WR1, ADDR1, DATO1, BE1, ACK1, ERR1, DATI1  same as requester 0, for requester 1
MREQ  out  1  memory request, held until MRDY
MWR  out  1  memory write strobe
MADDR  out  AW  memory address
MDATO  out  DW  memory write data
MBE  out  DW/8  memory byte enables
MDATI  in  DW  memory read data, valid when MRDY=1
MRDY  in  1  memory completion, qualifies MREQ
GNT  out  1  index of current/last granted requester (status)

Behaviour:
- Reset (RES=1 at an edge): state IDLE; MREQ, ACK0/1, ERR0/1 = 0; DATI0/1 = 0; wait counter = 0; LAST = 1, so requester 0 wins the first tie; GNT = 0. Reset mid-transaction abandons it: MREQ low the next cycle, no ACK issued.
- Requester rules: REQn and its fields are stable from assertion until the cycle ACKn=1. REQn still high in the cycle after ACKn is a new transaction.
- FSM IDLE: if neither REQ is high, stay. If one is high, grant it. If both are high, grant the one != LAST. On grant: latch the granted index into GNT, set LAST = grant, clear the counter, go to BUSY.
- FSM BUSY: MREQ=1. MWR/MADDR/MDATO/MBE are combinationally muxed from the granted requester's inputs; outside BUSY they are 0. The counter increments each BUSY cycle with MRDY=0.
  - MRDY=1: register MDATI into DATIg (writes also capture MDATI; the value is don't-care), go to RESP.
  - TOUT!=0, MRDY=0 and counter==TOUT-1: go to RESP with error. MREQ drops; DATIg = 0.
  - MRDY=1 in the same cycle as the timeout: the MRDY completion wins and ERR=0.
- FSM RESP: ACKg=1 for exactly one cycle. ERRg=1 only for a timeout abort. MREQ=0. Next state is IDLE.
- Latency: REQ seen at cycle 0 (IDLE) gives MREQ at cycle 1. MRDY at cycle 1 gives ACK at cycle 2. Minimum 3 cycles per transaction; the next grant is earliest at cycle 3.
- The non-granted requester's DATI/ACK/ERR are untouched; DATIn holds its last value.
- Never ACK0 and ACK1 in the same cycle. MREQ never asserts outside BUSY.
- REQ dropping illegally while granted is ignored: the transaction completes and ACK is still pulsed.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- Counter width: clog2(TOUT+1) bits, saturating, no wrap.

Test Plan:
- Single read on requester 0, ADDR0=0x100, memory returns MDATI=0xCAFEBABE with MRDY at cycle 1 -> MREQ at cycle 1 with MADDR=0x100, MWR=0; ACK0=1 with DATI0=0xCAFEBABE at cycle 2; ACK1 stays 0.
- Write on requester 1, ADDR1=0x2004, DATO1=0x12345678, BE1=4'b0011, MRDY delayed 3 cycles -> MREQ held 4 cycles with stable MADDR=0x2004, MDATO=0x12345678, MBE=4'b0011, MWR=1; single ACK1 pulse; ERR1=0.
- REQ0 and REQ1 asserted together, each re-requesting after every ACK, for 8 transactions -> grant order 0,1,0,1,0,1,0,1 with 3-cycle spacing and MRDY immediate.
- TOUT=4, REQ0 read, MRDY held 0 -> MREQ high for exactly 4 cycles, then ACK0=1, ERR0=1, DATI0=0; next request serviced normally.
- TOUT=4, MRDY=1 on the 4th wait cycle -> normal completion: ERR0=0, data returned.
- RES=1 for one cycle while in BUSY -> next cycle MREQ=0, no ACK, LAST=1, GNT=0; a subsequent simultaneous REQ0/REQ1 grants requester 0 first.
